// File: rtl/byteblast_pkg.sv
// Shared ByteBlast types and default sizing for the instruction-cycle sequencer.
package byteblast_pkg;

  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned MAX_EXEC_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

endpackage

// File: rtl/fde_pc_seq_if.sv
// Control/handshake bundle between the sequencer and memory/datapath control.
interface fde_pc_seq_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned EXEC_W = 3
);

  logic              enable;
  logic              mem_ready;
  logic [EXEC_W-1:0] exec_len;
  logic              load;
  logic [ADDR_W-1:0] nxt_adr;
  logic              halt;
  logic              fetch;
  logic              decode;
  logic              execute;
  logic              last_exec;
  logic              halted;
  logic [ADDR_W-1:0] crnt_adr;

  // Controller side: issues run/branch/halt requests, observes phases.
  modport master (
    output enable, mem_ready, exec_len, load, nxt_adr, halt,
    input  fetch, decode, execute, last_exec, halted, crnt_adr
  );

  // Sequencer side.
  modport slave (
    input  enable, mem_ready, exec_len, load, nxt_adr, halt,
    output fetch, decode, execute, last_exec, halted, crnt_adr
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter: increments or loads a branch target on each update strobe.
module pc_reg #(
  parameter int unsigned          ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]    RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd,
  input  logic              load,
  input  logic [ADDR_W-1:0] nxt_adr,
  output logic [ADDR_W-1:0] adr
);

  // Increment wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr <= RESET_VEC;
    end else if (upd) begin
      adr <= load ? nxt_adr : adr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fde_pc_seq.sv
// Fetch/decode/execute phase sequencer with integrated program counter.
module fde_pc_seq
  import byteblast_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       MAX_EXEC  = MAX_EXEC_DEF,
  parameter int unsigned       EXEC_W    = $clog2(MAX_EXEC + 1)
) (
  input  logic            clk,
  input  logic            reset,
  fde_pc_seq_if.slave     bus
);

  state_e            state, state_nxt;
  logic [EXEC_W-1:0] exec_cnt, exec_cnt_nxt;
  logic [EXEC_W-1:0] exec_n_c;
  logic              boundary_c;
  logic              fetch_d, decode_d, execute_d, last_exec_d, halted_d;

  // Clamp the requested execute length into 1..MAX_EXEC.
  always_comb begin
    exec_n_c = bus.exec_len;
    if (bus.exec_len == '0) begin
      exec_n_c = EXEC_W'(1);
    end else if (bus.exec_len > EXEC_W'(MAX_EXEC)) begin
      exec_n_c = EXEC_W'(MAX_EXEC);
    end
  end

  assign boundary_c = (state == ST_EXEC) && (exec_cnt == EXEC_W'(1));

  // State, remaining-exec counter and registered phase outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      exec_cnt      <= '0;
      bus.fetch     <= 1'b0;
      bus.decode    <= 1'b0;
      bus.execute   <= 1'b0;
      bus.last_exec <= 1'b0;
      bus.halted    <= 1'b0;
    end else begin
      state         <= state_nxt;
      exec_cnt      <= exec_cnt_nxt;
      bus.fetch     <= fetch_d;
      bus.decode    <= decode_d;
      bus.execute   <= execute_d;
      bus.last_exec <= last_exec_d;
      bus.halted    <= halted_d;
    end
  end

  // Next-state and counter logic; requests only matter at the boundary.
  always_comb begin
    state_nxt    = state;
    exec_cnt_nxt = exec_cnt;
    unique case (state)
      ST_IDLE: begin
        if (bus.enable) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.mem_ready) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        exec_cnt_nxt = exec_n_c;
        state_nxt    = ST_EXEC;
      end
      ST_EXEC: begin
        if (boundary_c) begin
          exec_cnt_nxt = '0;
          if (bus.halt)        state_nxt = ST_HALT;
          else if (bus.enable) state_nxt = ST_FETCH;
          else                 state_nxt = ST_IDLE;
        end else begin
          exec_cnt_nxt = exec_cnt - EXEC_W'(1);
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt    = ST_IDLE;
        exec_cnt_nxt = '0;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    fetch_d     = 1'b0;
    decode_d    = 1'b0;
    execute_d   = 1'b0;
    last_exec_d = 1'b0;
    halted_d    = 1'b0;
    unique case (state_nxt)
      ST_FETCH:  fetch_d  = 1'b1;
      ST_DECODE: decode_d = 1'b1;
      ST_EXEC: begin
        execute_d   = 1'b1;
        last_exec_d = (exec_cnt_nxt == EXEC_W'(1));
      end
      ST_HALT:   halted_d = 1'b1;
      default: ;
    endcase
  end

  pc_reg #(
    .ADDR_W    (ADDR_W),
    .RESET_VEC (RESET_VEC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (reset),
    .upd     (boundary_c),
    .load    (bus.load),
    .nxt_adr (bus.nxt_adr),
    .adr     (bus.crnt_adr)
  );

endmodule

// File: tb/tb_fde_pc_seq.sv
// Scoreboard bench for fde_pc_seq: per-cycle expectations queued by stimulus, checked by a monitor.
module tb_fde_pc_seq;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned EXEC_W = 3;

  logic clk;
  logic reset;

  fde_pc_seq_if #(.ADDR_W(ADDR_W), .EXEC_W(EXEC_W)) bus ();

  fde_pc_seq #(
    .ADDR_W    (ADDR_W),
    .RESET_VEC (8'h00),
    .MAX_EXEC  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Expected phase vector is {fetch, decode, execute, last_exec, halted}.
  logic [4:0] ph_q[$];
  logic [7:0] adr_q[$];
  string      nm_q[$];
  int         n_total = 0;
  int         n_pass  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare DUT outputs against the queued expectation mid-cycle.
  always @(negedge clk) begin
    if (ph_q.size() > 0) begin
      logic [4:0] e_ph;
      logic [7:0] e_adr;
      logic [4:0] a_ph;
      string      nm;
      e_ph  = ph_q.pop_front();
      e_adr = adr_q.pop_front();
      nm    = nm_q.pop_front();
      a_ph  = {bus.fetch, bus.decode, bus.execute, bus.last_exec, bus.halted};
      n_total++;
      if (a_ph === e_ph) n_pass++;
      else $display("FAIL %s phases got=%b exp=%b", nm, a_ph, e_ph);
      n_total++;
      if (bus.crnt_adr === e_adr) n_pass++;
      else $display("FAIL %s crnt_adr got=%02h exp=%02h", nm, bus.crnt_adr, e_adr);
    end
  end

  // Apply one cycle of inputs, queue the outputs expected during it, advance.
  task automatic step(input logic rst, input logic en, input logic mr,
                      input logic [2:0] len, input logic ld, input logic [7:0] na,
                      input logic ht, input string nm, input logic [4:0] ph,
                      input logic [7:0] adr);
    reset         = rst;
    bus.enable    = en;
    bus.mem_ready = mr;
    bus.exec_len  = len;
    bus.load      = ld;
    bus.nxt_adr   = na;
    bus.halt      = ht;
    ph_q.push_back(ph);
    adr_q.push_back(adr);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b0;
    bus.enable    = 1'b0;
    bus.mem_ready = 1'b0;
    bus.exec_len  = '0;
    bus.load      = 1'b0;
    bus.nxt_adr   = '0;
    bus.halt      = 1'b0;
    @(posedge clk);
    #1;

    step(0, 0, 0, 0, 0, 8'h00, 0, "rst",        5'b00000, 8'h00);
    step(0, 1, 1, 1, 0, 8'h00, 0, "rst_hold",   5'b00000, 8'h00);

    // Back-to-back single-exec instructions.
    step(1, 1, 1, 1, 0, 8'h00, 0, "s1_idle",    5'b00000, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 1, 0, 8'h00, 0, "s1_fetch", 5'b10000, 8'(i));
      step(1, 1, 1, 1, 0, 8'h00, 0, "s1_dec",   5'b01000, 8'(i));
      step(1, 1, 1, 1, 0, 8'h00, 0, "s1_exec",  5'b00110, 8'(i));
    end

    // Memory wait states, then a 3-cycle execute.
    step(1, 1, 0, 1, 0, 8'h00, 0, "s2_wait0",   5'b10000, 8'h04);
    step(1, 1, 0, 1, 0, 8'h00, 0, "s2_wait1",   5'b10000, 8'h04);
    step(1, 1, 1, 1, 0, 8'h00, 0, "s2_fetch",   5'b10000, 8'h04);
    step(1, 1, 1, 3, 0, 8'h00, 0, "s2_dec",     5'b01000, 8'h04);
    step(1, 1, 1, 3, 0, 8'h00, 0, "s3_exec1",   5'b00100, 8'h04);
    step(1, 1, 1, 3, 0, 8'h00, 0, "s3_exec2",   5'b00100, 8'h04);
    step(1, 1, 1, 3, 0, 8'h00, 0, "s3_exec3",   5'b00110, 8'h04);

    // Early load ignored, boundary load taken.
    step(1, 1, 1, 2, 0, 8'h00, 0, "s4_fetch5",  5'b10000, 8'h05);
    step(1, 1, 1, 2, 0, 8'h00, 0, "s4_dec5",    5'b01000, 8'h05);
    step(1, 1, 1, 2, 1, 8'h77, 0, "s4_ld_early",5'b00100, 8'h05);
    step(1, 1, 1, 2, 1, 8'h40, 0, "s4_ld_last", 5'b00110, 8'h05);

    // Non-boundary load/halt/enable are ignored.
    step(1, 1, 1, 3, 0, 8'h00, 0, "s4_fetch40", 5'b10000, 8'h40);
    step(1, 1, 1, 3, 0, 8'h00, 0, "s4_dec40",   5'b01000, 8'h40);
    step(1, 0, 1, 3, 1, 8'h99, 1, "s4_ign1",    5'b00100, 8'h40);
    step(1, 0, 1, 3, 0, 8'h00, 1, "s4_ign2",    5'b00100, 8'h40);
    step(1, 1, 1, 3, 0, 8'h00, 0, "s4_last40",  5'b00110, 8'h40);

    // exec_len=0 gives one exec cycle; load to FF.
    step(1, 1, 1, 0, 0, 8'h00, 0, "s3_fetch41", 5'b10000, 8'h41);
    step(1, 1, 1, 0, 0, 8'h00, 0, "s3_dec_l0",  5'b01000, 8'h41);
    step(1, 1, 1, 0, 1, 8'hFF, 0, "s3_exec_l0", 5'b00110, 8'h41);

    // exec_len=7 clamps to 4; PC wraps FF -> 00.
    step(1, 1, 1, 7, 0, 8'h00, 0, "s3_fetchFF", 5'b10000, 8'hFF);
    step(1, 1, 1, 7, 0, 8'h00, 0, "s3_dec_l7",  5'b01000, 8'hFF);
    step(1, 1, 1, 7, 0, 8'h00, 0, "s3_clamp1",  5'b00100, 8'hFF);
    step(1, 1, 1, 7, 0, 8'h00, 0, "s3_clamp2",  5'b00100, 8'hFF);
    step(1, 1, 1, 7, 0, 8'h00, 0, "s3_clamp3",  5'b00100, 8'hFF);
    step(1, 1, 1, 7, 0, 8'h00, 0, "s3_clamp4",  5'b00110, 8'hFF);

    // enable low at the boundary -> IDLE.
    step(1, 1, 1, 1, 0, 8'h00, 0, "s5_fetch00", 5'b10000, 8'h00);
    step(1, 1, 1, 1, 0, 8'h00, 0, "s5_dec00",   5'b01000, 8'h00);
    step(1, 0, 1, 1, 0, 8'h00, 0, "s5_to_idle", 5'b00110, 8'h00);
    step(1, 0, 1, 1, 0, 8'h00, 0, "s5_idle1",   5'b00000, 8'h01);
    step(1, 0, 1, 1, 0, 8'h00, 0, "s5_idle2",   5'b00000, 8'h01);
    step(1, 1, 1, 1, 0, 8'h00, 0, "s5_idle_go", 5'b00000, 8'h01);

    // Simultaneous load and halt.
    step(1, 1, 1, 1, 0, 8'h00, 0, "s5_fetch01", 5'b10000, 8'h01);
    step(1, 1, 1, 1, 0, 8'h00, 0, "s5_dec01",   5'b01000, 8'h01);
    step(1, 1, 1, 1, 1, 8'h10, 1, "s5_ld_halt", 5'b00110, 8'h01);
    step(1, 1, 1, 1, 0, 8'h00, 0, "s5_halt1",   5'b00001, 8'h10);
    step(1, 0, 1, 1, 0, 8'h00, 0, "s5_halt2",   5'b00001, 8'h10);
    step(1, 1, 0, 1, 0, 8'h00, 0, "s5_halt3",   5'b00001, 8'h10);

    // Asynchronous reset from HALT, then mid-DECODE.
    step(0, 1, 1, 1, 0, 8'h00, 0, "s6_halt_rst",5'b00000, 8'h00);
    step(1, 1, 1, 1, 0, 8'h00, 0, "s6_idle",    5'b00000, 8'h00);
    step(1, 1, 1, 1, 0, 8'h00, 0, "s6_fetch00", 5'b10000, 8'h00);
    step(1, 1, 1, 1, 0, 8'h00, 0, "s6_dec00",   5'b01000, 8'h00);
    step(1, 1, 1, 1, 0, 8'h00, 0, "s6_exec00",  5'b00110, 8'h00);
    step(1, 1, 1, 1, 0, 8'h00, 0, "s6_fetch01", 5'b10000, 8'h01);
    step(0, 1, 1, 1, 0, 8'h00, 0, "s6_dec_rst", 5'b00000, 8'h00);
    step(1, 1, 1, 1, 0, 8'h00, 0, "s6_restart", 5'b00000, 8'h00);
    step(1, 0, 1, 1, 0, 8'h00, 0, "s6_fetch",   5'b10000, 8'h00);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
